// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port (read/empty/dout, one-cycle latency) into a valid/ready stream
// through a 2-entry buffer. Define FIFO_READER_CNT_EN to add the word_count port.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  empty,
    output logic                  read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_count
`endif
);

    logic [1:0] occ_reg;
    logic [1:0] occ_next;
    logic       infl_reg;
    logic       head_reg;
    logic       tail_reg;
    logic       pop;
    logic [2:0] credit;
    logic [DATA_WIDTH-1:0] entry [2];

    assign out_valid = (occ_reg != 2'd0);
    assign out_data  = head_reg ? entry[1] : entry[0];

    // The pop is credited in the same cycle, so a full buffer can refill while draining.
    always_comb begin
        pop      = out_valid & out_ready;
        occ_next = occ_reg + {1'b0, infl_reg} - {1'b0, pop};
        credit   = {1'b0, occ_reg} + {2'b00, infl_reg} - {2'b00, pop};
        read     = rst & enable & ~empty & (credit < 3'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_reg  <= 2'd0;
            infl_reg <= 1'b0;
            head_reg <= 1'b0;
            tail_reg <= 1'b0;
        end else begin
            occ_reg  <= occ_next;
            infl_reg <= read;
            if (pop)
                head_reg <= ~head_reg;
            if (infl_reg)
                tail_reg <= ~tail_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    entry_reg <= '0;
                else if (infl_reg && (tail_reg == 1'(gi)))
                    entry_reg <= dout;
            end

            assign entry[gi] = entry_reg;
        end
    endgenerate

`ifdef FIFO_READER_CNT_EN
    logic [CNT_WIDTH-1:0] word_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            word_count_reg <= '0;
        else if (pop)
            word_count_reg <= word_count_reg + 1'b1;
    end

    assign word_count = word_count_reg;
`else
    // CNT_WIDTH only sizes the counter; keep the parameter referenced when it is absent.
    logic [CNT_WIDTH-1:0] unused_cnt_width;
    assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, expected words are
// queued on load and a forked monitor checks every accepted word and the hold/occupancy rules.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dout = '0;
    logic          empty;
    logic          read;
    logic [DW-1:0] out_data;
    logic          out_valid;
`ifdef FIFO_READER_CNT_EN
    logic [CW-1:0] word_count;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .dout      (dout),
        .empty     (empty),
        .read      (read),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_READER_CNT_EN
        ,
        .word_count(word_count)
`endif
    );

    // FIFO model: one-cycle read latency
    logic [DW-1:0] fifo_mem [0:127];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (read) begin
            dout   <= fifo_mem[rd_ptr[6:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int            checks = 0;
    int            errors = 0;
    int            n_reads = 0;
    int            n_pops = 0;
    logic [DW-1:0] exp_q [$];
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        fifo_mem[wr_ptr[6:0]] = v;
        wr_ptr++;
        exp_q.push_back(v);
        $display("load word 0x%02h", v);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int            r0;
        int            p0;
        logic [11:0]   rh;
        logic [11:0]   vh;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        check("hold_valid", out_valid, 1);
                        check("hold_data", out_data, prev_data);
                    end
                    if (read) begin
                        n_reads++;
                        check("read_not_empty", empty, 0);
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word: got 0x%02h, expected no word", out_data);
                        end else begin
                            $display("pop word 0x%02h (expect 0x%02h)", out_data, exp_q[0]);
                            check("stream_data", out_data, exp_q.pop_front());
                        end
                        n_pops++;
                    end
                    check("occupancy_le2", ((n_reads - n_pops) <= 2), 1);
                    prev_stall = out_valid && !out_ready;
                    prev_data  = out_data;
                end
            end
        join_none

        // Reset with the FIFO pre-loaded
        load(8'h55);
        load(8'h66);
        repeat (3) begin
            @(negedge clk);
            check("reset_read", read, 0);
            check("reset_valid", out_valid, 0);
            check("reset_data", out_data, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("first_read", read, 1);
        drain(50);

        // Streaming 0x11..0x18
        for (int i = 0; i < 8; i++) load(8'(8'h11 + i));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rh[i] = read;
            vh[i] = out_valid;
        end
        check("stream_read_pattern", {20'd0, rh}, 32'h0FF);
        check("stream_valid_pattern", {20'd0, vh}, 32'h3FC);
        drain(50);

        // Backpressure 0xA0..0xA5
        out_ready = 1'b0;
        r0 = n_reads;
        for (int i = 0; i < 6; i++) load(8'(8'hA0 + i));
        repeat (10) @(negedge clk);
        #1;
        check("stall_reads", n_reads - r0, 2);
        check("stall_valid", out_valid, 1);
        check("stall_head", out_data, 8'hA0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(50);
        check("bp_total_reads", n_reads - r0, 6);

        // Alternating out_ready with 8 words
        r0 = n_reads;
        for (int i = 0; i < 8; i++) load(8'(8'h30 + i));
        for (int k = 0; k < 60 && (exp_q.size() != 0 || out_valid); k++) begin
            out_ready = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        check("alt_drained", exp_q.size(), 0);
        check("alt_reads", n_reads - r0, 8);
        out_ready = 1'b1;
        drain(10);

        // enable dropped after the 3rd read
        r0 = n_reads;
        p0 = n_pops;
        for (int i = 1; i <= 5; i++) load(8'(i));
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("disabled_reads", n_reads - r0, 3);
        check("disabled_pops", n_pops - p0, 3);
        check("disabled_valid", out_valid, 0);
        enable = 1'b1;
        drain(50);
        check("enable_total_reads", n_reads - r0, 5);

`ifdef FIFO_READER_CNT_EN
        // Counter wrap with CNT_WIDTH = 4
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("count_async_clear", word_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 18; i++) load(8'(8'h80 + i));
        drain(100);
        check("count_wrap", word_count, 2);
`endif

        // Asynchronous reset mid-stream with two words held
        out_ready = 1'b0;
        load(8'hC0);
        load(8'hC1);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_read", read, 0);
        check("async_data", out_data, 0);
`ifdef FIFO_READER_CNT_EN
        check("async_count", word_count, 0);
`endif
        exp_q.delete();
        n_reads = 0;
        n_pops = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        load(8'hE7);
        drain(50);
        check("post_reset_reads", n_reads, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
